// File: rtl/cp0_pkg.sv
// Shared CP0 register numbers, exception codes, field positions and write masks.
package cp0_pkg;

    localparam logic [4:0] CP0_BADVADDR = 5'd8;
    localparam logic [4:0] CP0_COUNT    = 5'd9;
    localparam logic [4:0] CP0_COMPARE  = 5'd11;
    localparam logic [4:0] CP0_STATUS   = 5'd12;
    localparam logic [4:0] CP0_CAUSE    = 5'd13;
    localparam logic [4:0] CP0_EPC      = 5'd14;

    localparam logic [31:0] EXC_INT  = 32'h01;
    localparam logic [31:0] EXC_ADEL = 32'h04;
    localparam logic [31:0] EXC_ADES = 32'h05;
    localparam logic [31:0] EXC_SYS  = 32'h08;
    localparam logic [31:0] EXC_BP   = 32'h09;
    localparam logic [31:0] EXC_RI   = 32'h0A;
    localparam logic [31:0] EXC_OV   = 32'h0C;
    localparam logic [31:0] EXC_ERET = 32'h0E;

    localparam int unsigned STATUS_EXL   = 1;
    localparam int unsigned CAUSE_BD     = 31;
    localparam int unsigned CAUSE_IP_HI  = 15;
    localparam int unsigned CAUSE_IP_LO  = 10;
    localparam int unsigned CAUSE_EXC_HI = 6;
    localparam int unsigned CAUSE_EXC_LO = 2;

    localparam logic [31:0] STATUS_WMASK = 32'h0000_FF03;
    localparam logic [31:0] CAUSE_WMASK  = 32'h0000_0300;

    function automatic logic [31:0] masked_write(input logic [31:0] old_val,
                                                 input logic [31:0] new_val,
                                                 input logic [31:0] mask);
        return (old_val & ~mask) | (new_val & mask);
    endfunction

endpackage

// File: rtl/cp0_timer.sv
// Count/Compare pair with the Count prescaler and the sticky timer interrupt.
module cp0_timer
    import cp0_pkg::*;
#(
    parameter int unsigned COUNT_DIV = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        count_we,
    input  logic        compare_we,
    input  logic [31:0] wdata,
    output logic [31:0] count,
    output logic [31:0] compare,
    output logic        timer_int
);

    logic phase;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
            phase <= 1'b0;
        end else if (count_we) begin
            count <= wdata;
            phase <= 1'b0;
        end else begin
            if (COUNT_DIV == 1 || phase)
                count <= count + 32'd1;
            phase <= (COUNT_DIV == 1) ? 1'b0 : ~phase;
        end
    end

    // A Compare write acknowledges the interrupt and beats a same-cycle match.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            compare   <= '0;
            timer_int <= 1'b0;
        end else if (compare_we) begin
            compare   <= wdata;
            timer_int <= 1'b0;
        end else if (count == compare) begin
            timer_int <= 1'b1;
        end
    end

endmodule

// File: rtl/cp0_regfile.sv
// Coprocessor-0 register file: MTC0/MFC0 access, exception/ERET commit, timer interrupt.
module cp0_regfile
    import cp0_pkg::*;
#(
    parameter int unsigned COUNT_DIV    = 2,
    parameter logic [31:0] STATUS_RESET = 32'h0040_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        we,
    input  logic [4:0]  waddr,
    input  logic [31:0] wdata,
    input  logic [4:0]  raddr,
    output logic [31:0] rdata,
    input  logic [5:0]  ext_int,
    input  logic [31:0] excepttype,
    input  logic [31:0] except_inst_addr,
    input  logic [31:0] except_bad_addr,
    input  logic        except_in_delayslot,
    output logic [31:0] cp0_status,
    output logic [31:0] cp0_cause,
    output logic [31:0] cp0_epc,
    output logic [31:0] cp0_badvaddr,
    output logic [31:0] cp0_count,
    output logic [31:0] cp0_compare,
    output logic        timer_int
);

    logic        exc_commit;
    logic        eret_commit;
    logic [31:0] status_nxt;
    logic [31:0] cause_nxt;
    logic [31:0] epc_nxt;
    logic [31:0] badvaddr_nxt;

    assign exc_commit  = (excepttype != '0) && (excepttype != EXC_ERET);
    assign eret_commit = (excepttype == EXC_ERET);

    cp0_timer #(
        .COUNT_DIV (COUNT_DIV)
    ) u_timer (
        .clk        (clk),
        .rst        (rst),
        .count_we   (we && waddr == CP0_COUNT),
        .compare_we (we && waddr == CP0_COMPARE),
        .wdata      (wdata),
        .count      (cp0_count),
        .compare    (cp0_compare),
        .timer_int  (timer_int)
    );

    // MTC0 is applied first, then commit/ERET overwrite only the fields they own.
    always_comb begin
        status_nxt   = cp0_status;
        cause_nxt    = cp0_cause;
        epc_nxt      = cp0_epc;
        badvaddr_nxt = cp0_badvaddr;

        if (we && waddr == CP0_STATUS)
            status_nxt = masked_write(cp0_status, wdata, STATUS_WMASK);
        if (we && waddr == CP0_CAUSE)
            cause_nxt = masked_write(cp0_cause, wdata, CAUSE_WMASK);
        if (we && waddr == CP0_EPC)
            epc_nxt = wdata;

        cause_nxt[CAUSE_IP_HI:CAUSE_IP_LO] = {ext_int[5] | timer_int, ext_int[4:0]};

        if (exc_commit) begin
            if (!cp0_status[STATUS_EXL]) begin
                epc_nxt             = except_in_delayslot ? except_inst_addr - 32'd4
                                                          : except_inst_addr;
                cause_nxt[CAUSE_BD] = except_in_delayslot;
            end
            status_nxt[STATUS_EXL] = 1'b1;
            cause_nxt[CAUSE_EXC_HI:CAUSE_EXC_LO] =
                (excepttype == EXC_INT) ? 5'd0 : excepttype[4:0];
            if (excepttype == EXC_ADEL || excepttype == EXC_ADES)
                badvaddr_nxt = except_bad_addr;
        end else if (eret_commit) begin
            status_nxt[STATUS_EXL] = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cp0_status   <= STATUS_RESET;
            cp0_cause    <= '0;
            cp0_epc      <= '0;
            cp0_badvaddr <= '0;
        end else begin
            cp0_status   <= status_nxt;
            cp0_cause    <= cause_nxt;
            cp0_epc      <= epc_nxt;
            cp0_badvaddr <= badvaddr_nxt;
        end
    end

    always_comb begin
        rdata = '0;
        case (raddr)
            CP0_BADVADDR: rdata = cp0_badvaddr;
            CP0_COUNT:    rdata = cp0_count;
            CP0_COMPARE:  rdata = cp0_compare;
            CP0_STATUS:   rdata = cp0_status;
            CP0_CAUSE:    rdata = cp0_cause;
            CP0_EPC:      rdata = cp0_epc;
            default:      rdata = '0;
        endcase
    end

endmodule

// File: tb/tb_cp0_regfile.sv
// Directed self-checking bench for cp0_regfile.
module tb_cp0_regfile;

    logic        clk;
    logic        rst;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [4:0]  raddr;
    logic [31:0] rdata;
    logic [5:0]  ext_int;
    logic [31:0] excepttype;
    logic [31:0] except_inst_addr;
    logic [31:0] except_bad_addr;
    logic        except_in_delayslot;
    logic [31:0] cp0_status;
    logic [31:0] cp0_cause;
    logic [31:0] cp0_epc;
    logic [31:0] cp0_badvaddr;
    logic [31:0] cp0_count;
    logic [31:0] cp0_compare;
    logic        timer_int;

    int checks = 0;
    int errors = 0;

    cp0_regfile #(
        .COUNT_DIV    (2),
        .STATUS_RESET (32'h0040_0000)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .we                  (we),
        .waddr               (waddr),
        .wdata               (wdata),
        .raddr               (raddr),
        .rdata               (rdata),
        .ext_int             (ext_int),
        .excepttype          (excepttype),
        .except_inst_addr    (except_inst_addr),
        .except_bad_addr     (except_bad_addr),
        .except_in_delayslot (except_in_delayslot),
        .cp0_status          (cp0_status),
        .cp0_cause           (cp0_cause),
        .cp0_epc             (cp0_epc),
        .cp0_badvaddr        (cp0_badvaddr),
        .cp0_count           (cp0_count),
        .cp0_compare         (cp0_compare),
        .timer_int           (timer_int)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
        we = 1'b1; waddr = a; wdata = d;
        tick();
        we = 1'b0;
    endtask

    task automatic commit(input logic [31:0] t, input logic [31:0] pc,
                          input logic [31:0] bad, input logic ds);
        excepttype = t; except_inst_addr = pc; except_bad_addr = bad; except_in_delayslot = ds;
        tick();
        excepttype = '0; except_inst_addr = '0; except_bad_addr = '0; except_in_delayslot = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        mtc0(5'd14, 32'h0000_1234);
        mtc0(5'd9, 32'h0000_0010);
        checks++;
        if (cp0_count !== 32'h10) begin
            errors++; $display("FAIL pre_reset_count got %h exp %h", cp0_count, 32'h10);
        end
        #2 rst = 1'b1;
        #1;
        raddr = 5'd12;
        #1;
        checks++;
        if (cp0_status !== 32'h0040_0000 || cp0_count !== '0 || cp0_epc !== '0 ||
            cp0_cause !== '0 || cp0_badvaddr !== '0 || cp0_compare !== '0 || timer_int !== 1'b0) begin
            errors++;
            $display("FAIL async_reset got st=%h cnt=%h epc=%h cause=%h bad=%h cmp=%h ti=%b",
                     cp0_status, cp0_count, cp0_epc, cp0_cause, cp0_badvaddr, cp0_compare, timer_int);
        end
        checks++;
        if (rdata !== 32'h0040_0000) begin
            errors++; $display("FAIL reset_rdata got %h exp %h", rdata, 32'h0040_0000);
        end
        tick();
        rst = 1'b0;
    endtask

    task automatic test_timer();
        mtc0(5'd11, 32'd5);
        mtc0(5'd9, 32'd0);
        checks++;
        if (cp0_count !== 32'd0 || timer_int !== 1'b0) begin
            errors++; $display("FAIL timer_start got cnt=%h ti=%b exp 0/0", cp0_count, timer_int);
        end
        repeat (9) tick();
        checks++;
        if (cp0_count !== 32'd4 || timer_int !== 1'b0) begin
            errors++; $display("FAIL timer_e9 got cnt=%h ti=%b exp 4/0", cp0_count, timer_int);
        end
        tick();
        checks++;
        if (cp0_count !== 32'd5 || timer_int !== 1'b0) begin
            errors++; $display("FAIL timer_e10 got cnt=%h ti=%b exp 5/0", cp0_count, timer_int);
        end
        tick();
        checks++;
        if (timer_int !== 1'b1 || cp0_count !== 32'd5) begin
            errors++; $display("FAIL timer_fire got ti=%b cnt=%h exp 1/5", timer_int, cp0_count);
        end
        raddr = 5'd9;
        tick();
        checks++;
        if (timer_int !== 1'b1 || cp0_cause[15] !== 1'b1 || rdata !== 32'd6) begin
            errors++; $display("FAIL timer_sticky got ti=%b ip7=%b rd=%h exp 1/1/6",
                               timer_int, cp0_cause[15], rdata);
        end
        mtc0(5'd11, 32'h20);
        checks++;
        if (timer_int !== 1'b0 || cp0_compare !== 32'h20) begin
            errors++; $display("FAIL timer_clear got ti=%b cmp=%h exp 0/20", timer_int, cp0_compare);
        end
        mtc0(5'd9, 32'h20);
        mtc0(5'd11, 32'h40);
        checks++;
        if (timer_int !== 1'b0) begin
            errors++; $display("FAIL timer_write_wins got ti=%b exp 0", timer_int);
        end
        tick();
        checks++;
        if (timer_int !== 1'b0 || cp0_count !== 32'h21) begin
            errors++; $display("FAIL timer_after_win got ti=%b cnt=%h exp 0/21", timer_int, cp0_count);
        end
        mtc0(5'd9, 32'hFFFF_FFFF);
        tick();
        checks++;
        if (cp0_count !== 32'hFFFF_FFFF) begin
            errors++; $display("FAIL count_pre_wrap got %h exp ffffffff", cp0_count);
        end
        tick();
        checks++;
        if (cp0_count !== 32'd0) begin
            errors++; $display("FAIL count_wrap got %h exp 0", cp0_count);
        end
    endtask

    task automatic test_adel_delayslot();
        commit(32'h4, 32'hBFC0_0104, 32'h0000_0003, 1'b1);
        checks++;
        if (cp0_epc !== 32'hBFC0_0100 || cp0_cause[31] !== 1'b1 || cp0_cause[6:2] !== 5'd4 ||
            cp0_badvaddr !== 32'h3 || cp0_status[1] !== 1'b1) begin
            errors++;
            $display("FAIL adel_ds got epc=%h bd=%b code=%h bad=%h exl=%b exp bfc00100/1/04/3/1",
                     cp0_epc, cp0_cause[31], cp0_cause[6:2], cp0_badvaddr, cp0_status[1]);
        end
    endtask

    task automatic test_nested();
        commit(32'h8, 32'h8000_0000, 32'hDEAD_BEEF, 1'b0);
        checks++;
        if (cp0_epc !== 32'hBFC0_0100 || cp0_cause[6:2] !== 5'd8 || cp0_cause[31] !== 1'b1 ||
            cp0_badvaddr !== 32'h3 || cp0_status[1] !== 1'b1) begin
            errors++;
            $display("FAIL nested got epc=%h code=%h bd=%b bad=%h exl=%b exp bfc00100/08/1/3/1",
                     cp0_epc, cp0_cause[6:2], cp0_cause[31], cp0_badvaddr, cp0_status[1]);
        end
    endtask

    task automatic test_eret_mtc0();
        we = 1'b1; waddr = 5'd12; wdata = 32'h0000_FF03;
        commit(32'hE, 32'h0, 32'h0, 1'b0);
        we = 1'b0;
        checks++;
        if (cp0_status !== 32'h0040_FF01) begin
            errors++; $display("FAIL eret_mtc0 got %h exp 0040ff01", cp0_status);
        end
    endtask

    task automatic test_interrupt();
        commit(32'h1, 32'h8000_1000, 32'h0, 1'b0);
        checks++;
        if (cp0_cause[6:2] !== 5'd0 || cp0_epc !== 32'h8000_1000 || cp0_cause[31] !== 1'b0 ||
            cp0_status !== 32'h0040_FF03) begin
            errors++;
            $display("FAIL int_code got code=%h epc=%h bd=%b st=%h exp 00/80001000/0/0040ff03",
                     cp0_cause[6:2], cp0_epc, cp0_cause[31], cp0_status);
        end
        ext_int = 6'b000001;
        checks++;
        if (cp0_cause[10] !== 1'b0) begin
            errors++; $display("FAIL ip_latency got %b exp 0", cp0_cause[10]);
        end
        tick();
        checks++;
        if (cp0_cause !== 32'h0000_0400) begin
            errors++; $display("FAIL ip_sample got %h exp 00000400", cp0_cause);
        end
        mtc0(5'd13, 32'hFFFF_FFFF);
        raddr = 5'd13;
        #1;
        checks++;
        if (rdata !== 32'h0000_0700) begin
            errors++; $display("FAIL cause_mask got %h exp 00000700", rdata);
        end
    endtask

    task automatic test_access();
        mtc0(5'd8, 32'h5555_5555);
        checks++;
        if (cp0_badvaddr !== 32'h3) begin
            errors++; $display("FAIL badvaddr_ro got %h exp 3", cp0_badvaddr);
        end
        mtc0(5'd12, 32'h0000_0000);
        checks++;
        if (cp0_status !== 32'h0040_0000) begin
            errors++; $display("FAIL status_mask got %h exp 00400000", cp0_status);
        end
        raddr = 5'd14;
        we = 1'b1; waddr = 5'd14; wdata = 32'hCAFE_0000;
        #1;
        checks++;
        if (rdata !== 32'h8000_1000) begin
            errors++; $display("FAIL no_bypass got %h exp 80001000", rdata);
        end
        tick();
        we = 1'b0;
        checks++;
        if (rdata !== 32'hCAFE_0000) begin
            errors++; $display("FAIL epc_write got %h exp cafe0000", rdata);
        end
        raddr = 5'd10;
        mtc0(5'd10, 32'h1234_5678);
        checks++;
        if (rdata !== 32'd0) begin
            errors++; $display("FAIL unmapped_read got %h exp 0", rdata);
        end
    endtask

    initial begin
        rst = 1'b1; we = 1'b0; waddr = '0; wdata = '0; raddr = '0; ext_int = '0;
        excepttype = '0; except_inst_addr = '0; except_bad_addr = '0; except_in_delayslot = 1'b0;
        test_reset();
        test_timer();
        test_adel_delayslot();
        test_nested();
        test_eret_mtc0();
        test_interrupt();
        test_access();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cp0_regfile.md
Name: cp0_regfile

Overview:
- Coprocessor-0 state holder and updater for the dual-issue core.
- Holds Status, Cause, EPC, BadVAddr, Count and Compare.
- Feeds cp0_status/cp0_cause/cp0_epc to the exception unit and consumes that unit's decided excepttype, except_inst_addr, except_bad_addr and except_in_delayslot to commit exception/ERET state.
- Also services MTC0/MFC0 and generates the timer interrupt.

Parameters:
- COUNT_DIV, 2, Count increments once every COUNT_DIV clock cycles (legal values 1 or 2).
- STATUS_RESET, 32'h0040_0000, Status reset value (BEV=1).

Ports:
- clk  in  1  core clock
- rst  in  1  reset: asynchronous, active-high
- we  in  1  MTC0 write enable (from commit stage, master slot)
- waddr  in  5  MTC0 register number
- wdata  in  32  MTC0 data
- raddr  in  5  MFC0 register number
- rdata  out  32  MFC0 data, combinational
- ext_int  in  6  hardware interrupt lines HW5..HW0, level-sensitive
- excepttype  in  32  committed exception code from the exception unit; 0 = none
- except_inst_addr  in  32  PC of the excepting instruction
- except_bad_addr  in  32  faulting address for AdEL/AdES
- except_in_delayslot  in  1  excepting instruction is in a delay slot
- cp0_status  out  32  Status (reg 12)
- cp0_cause  out  32  Cause (reg 13)
- cp0_epc  out  32  EPC (reg 14)
- cp0_badvaddr  out  32  BadVAddr (reg 8)
- cp0_count  out  32  Count (reg 9)
- cp0_compare  out  32  Compare (reg 11)
- timer_int  out  1  timer interrupt pending

Behaviour:
- Reset (async): status=STATUS_RESET; cause, epc, badvaddr, count, compare = 0; timer_int=0; divider phase=0. rdata follows the read mux.
- All register updates take effect at the next rising edge (1-cycle latency).
- rdata mux:
  - 8→badvaddr, 9→count, 11→compare, 12→status, 13→cause, 14→epc, others→0.
  - No bypass of a same-cycle write.
- Count:
  - Divider phase toggles each cycle (COUNT_DIV=2); count+1 when phase=1; wraps 32'hFFFF_FFFF→0.
  - MTC0 to Count loads wdata and clears the phase; the write wins over the increment.
- Compare and timer:
  - MTC0 to Compare loads wdata and clears timer_int.
  - timer_int set when count==compare (registered, sticky until a Compare write).
  - Same-cycle match and Compare write: the write wins, so timer_int=0.
- Cause.IP:
  - IP[7:2] (bits 15:10) sampled every cycle = {ext_int[5] | timer_int, ext_int[4:0]}; not writable.
  - IP[1:0] (bits 9:8) writable by MTC0.
- MTC0 write masks:
  - Status bits 15:8, 1, 0.
  - Cause bits 9:8.
  - EPC and Compare full 32 bits.
  - BadVAddr read-only.
  - Writes to any other register are ignored.
- Exception commit (excepttype != 0 and != 32'h0E):
  - If Status.EXL==0: epc ← in_delayslot ? except_inst_addr−4 : except_inst_addr, and Cause.BD(31) ← in_delayslot. If EXL==1 already, epc and BD are unchanged.
  - Status.EXL ← 1.
  - Cause.ExcCode(6:2) ← 0 for excepttype 1 (interrupt), else excepttype[4:0].
  - For excepttype 4 or 5: badvaddr ← except_bad_addr.
- ERET (excepttype==32'h0E): Status.EXL ← 0.
- Priority in one cycle: exception commit/ERET overrides a simultaneous MTC0 to the same field; unrelated fields still take the MTC0 write. Count/timer/IP sampling continue regardless.
- Undefined excepttype values other than those listed still set EXL and load ExcCode from [4:0].

Decomposition:
- Shared package cp0_pkg:
  - Register-number constants CP0_BADVADDR=8, COUNT=9, COMPARE=11, STATUS=12, CAUSE=13, EPC=14.
  - excepttype codes EXC_INT=1, ADEL=4, ADES=5, SYS=8, BP=9, RI=0xA, OV=0xC, ERET=0xE.
  - Status/Cause bit-index constants and write masks.
- One natural sub-module: cp0_timer (Count, divider, Compare, timer_int).

Test Plan:
- Reset mid-run: rst pulse while count=0x10 → all outputs read reset values asynchronously; status=0x0040_0000, count=0.
- Timer: write Compare=5, Count=0 → count reaches 5 after 10 cycles, then timer_int=1 and cause[15]=1. Write Compare=0x20 → timer_int=0 the next cycle.
- AdEL in delay slot:
  - Stimulus: excepttype=4, pc=0xBFC0_0104, bad=0x0000_0003, ds=1, EXL=0.
  - Response: epc=0xBFC0_0100, cause[31]=1, ExcCode=4, badvaddr=3, EXL=1.
- Nested exception: with EXL=1, excepttype=8, pc=0x8000_0000 → epc unchanged, ExcCode=8.
- ERET plus MTC0 Status same cycle: wdata=0x0000_FF03 with excepttype=0xE → IM=0xFF, IE=1, EXL=0.
- Interrupt code mapping: excepttype=1 → ExcCode=0. Also ext_int=6'b000001 → cause[10]=1 one cycle later; MTC0 Cause=0xFFFF_FFFF → only bits 9:8 change.
